// File: rtl/fios_pkg.sv
// Shared limb width and collector state encoding for the FIOS result collector.
package fios_pkg;
  localparam int LIMB_WIDTH = 17;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN
  } collector_state_t;
endpackage

// File: rtl/limb_serial_subtractor.sv
// Limb-serial res - p subtractor with a borrow register; used only when FIOS_FINAL_SUB_EN is defined.
module limb_serial_subtractor
  import fios_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [LIMB_WIDTH-1:0] a,
  input  logic [LIMB_WIDTH-1:0] b,
  output logic [LIMB_WIDTH-1:0] diff,
  output logic                  borrow_out
);
  logic                borrow_reg;
  logic [LIMB_WIDTH:0] t;

  // The extra top bit of the difference is the borrow into the next limb.
  assign t          = {1'b0, a} - {1'b0, b} - {{LIMB_WIDTH{1'b0}}, borrow_reg};
  assign diff       = t[LIMB_WIDTH-1:0];
  assign borrow_out = t[LIMB_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      borrow_reg <= 1'b0;
    end else if (clear) begin
      borrow_reg <= 1'b0;
    end else if (enable) begin
      borrow_reg <= t[LIMB_WIDTH];
    end
  end
endmodule

// File: rtl/fios_result_collector.sv
// Captures S result limbs from the PE chain and re-emits them under valid/ready (S >= 2).
// FIOS_FINAL_SUB_EN enables the limb-serial final conditional subtraction of p.
module fios_result_collector
  import fios_pkg::*;
#(
  parameter int S = 16
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  res_valid_i,
  input  logic [LIMB_WIDTH-1:0] res_i,
  input  logic [LIMB_WIDTH-1:0] p_i,
  input  logic                  out_ready_i,
  output logic                  out_valid_o,
  output logic [LIMB_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic                  done_o
);
  localparam int CNT_W = (S > 1) ? $clog2(S) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(S - 1);

  collector_state_t state_reg, state_next;

  logic [CNT_W-1:0]      in_idx_reg;
  logic [CNT_W-1:0]      out_idx_reg;
  logic [CNT_W-1:0]      next_idx;
  logic [LIMB_WIDTH-1:0] out_data_reg;
  logic                  done_reg;
  logic [LIMB_WIDTH-1:0] raw_mem [S];

  logic                  arm;
  logic                  accept;
  logic                  last_accept;
  logic                  handshake;
  logic                  last_handshake;
  logic [LIMB_WIDTH-1:0] first_limb;
  logic [LIMB_WIDTH-1:0] next_limb;

  assign accept         = (state_reg == COLLECT) && res_valid_i;
  assign last_accept    = accept && (in_idx_reg == LAST_IDX);
  assign out_valid_o    = (state_reg == DRAIN);
  assign out_last_o     = out_valid_o && (out_idx_reg == LAST_IDX);
  assign handshake      = out_valid_o && out_ready_i;
  assign last_handshake = handshake && out_last_o;
  assign next_idx       = out_last_o ? '0 : out_idx_reg + 1'b1;
  assign out_data_o     = out_data_reg;
  assign busy_o         = (state_reg != IDLE);
  assign done_o         = done_reg;

  always_comb begin
    state_next = state_reg;
    arm        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          state_next = COLLECT;
          arm        = 1'b1;
        end
      end
      COLLECT: begin
        if (last_accept) state_next = DRAIN;
      end
      DRAIN: begin
        if (last_handshake) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg    <= IDLE;
      in_idx_reg   <= '0;
      out_idx_reg  <= '0;
      out_data_reg <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= last_handshake;
      if (arm) begin
        in_idx_reg <= '0;
      end else if (accept) begin
        in_idx_reg <= in_idx_reg + 1'b1;
      end
      // Output limb is pre-read one cycle ahead so the RAM read stays registered.
      if (last_accept) begin
        out_idx_reg  <= '0;
        out_data_reg <= first_limb;
      end else if (handshake) begin
        out_idx_reg  <= next_idx;
        out_data_reg <= next_limb;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (accept) raw_mem[in_idx_reg] <= res_i;
  end

`ifdef FIOS_FINAL_SUB_EN
  logic [LIMB_WIDTH-1:0] diff_mem [S];
  logic [LIMB_WIDTH-1:0] diff_limb;
  logic                  borrow_next;
  logic                  sel_reg;
  logic                  sel_next;

  limb_serial_subtractor u_subtractor (
    .clk        (clock_i),
    .rst        (reset_i),
    .clear      (arm),
    .enable     (accept),
    .a          (res_i),
    .b          (p_i),
    .diff       (diff_limb),
    .borrow_out (borrow_next)
  );

  always_ff @(posedge clock_i) begin
    if (accept) diff_mem[in_idx_reg] <= diff_limb;
  end

  // No borrow out of the top limb means res >= p, so the difference is the result.
  assign sel_next = ~borrow_next;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      sel_reg <= 1'b0;
    end else if (last_accept) begin
      sel_reg <= sel_next;
    end
  end

  assign first_limb = sel_next ? diff_mem[0] : raw_mem[0];
  assign next_limb  = sel_reg ? diff_mem[next_idx] : raw_mem[next_idx];
`else
  logic unused_p;

  assign unused_p   = ^p_i;
  assign first_limb = raw_mem[0];
  assign next_limb  = raw_mem[next_idx];
`endif
endmodule

// File: tb/tb_fios_result_collector.sv
// Randomized self-checking bench for fios_result_collector (S=4) against a whole-number model.
module tb_fios_result_collector;
  localparam int S  = 4;
  localparam int LW = 17;
`ifdef FIOS_FINAL_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          start_i;
  logic          res_valid_i;
  logic [LW-1:0] res_i;
  logic [LW-1:0] p_i;
  logic          out_ready_i;
  logic          out_valid_o;
  logic [LW-1:0] out_data_o;
  logic          out_last_o;
  logic          busy_o;
  logic          done_o;

  int checks_total  = 0;
  int checks_passed = 0;

  fios_result_collector #(.S(S)) dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .res_valid_i (res_valid_i),
    .res_i       (res_i),
    .p_i         (p_i),
    .out_ready_i (out_ready_i),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  function automatic logic [S*LW-1:0] pack4(input logic [LW-1:0] a0, input logic [LW-1:0] a1,
                                            input logic [LW-1:0] a2, input logic [LW-1:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  // Result as a whole number: optionally reduced once by p when it is not below p.
  function automatic logic [S*LW-1:0] expect_result(input logic [S*LW-1:0] r, input logic [S*LW-1:0] p);
    if (SUB_EN && (r >= p)) return r - p;
    return r;
  endfunction

  // mode 0: ready always high; 1: random ready; 2: 3-cycle stall after the 2nd limb
  task automatic run_op(input string tag, input logic [S*LW-1:0] r, input logic [S*LW-1:0] p, input int mode);
    logic [S*LW-1:0] exp_v;
    logic [LW-1:0]   exp_limb;
    int k;
    int cyc;
    int stall;
    exp_v = expect_result(r, p);
    $display("op %s: res=%h p=%h expect=%h mode=%0d", tag, r, p, exp_v, mode);
    // junk res_valid_i in IDLE must not start anything
    start_i     = 1'b0;
    res_valid_i = 1'b1;
    res_i       = LW'($urandom);
    tick();
    @(negedge clock_i);
    check_eq({tag, ".idle_busy"}, busy_o, 1'b0);
    tick();
    res_valid_i = 1'b0;
    start_i     = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < S; i++) begin
      while ($urandom_range(0, 2) == 0) begin
        res_valid_i = 1'b0;
        res_i       = LW'($urandom);
        p_i         = LW'($urandom);
        start_i     = 1'($urandom_range(0, 1));
        tick();
      end
      start_i     = 1'b0;
      res_valid_i = 1'b1;
      res_i       = r[i*LW +: LW];
      p_i         = p[i*LW +: LW];
      tick();
    end
    k     = 0;
    cyc   = 0;
    stall = 0;
    while (k < S && cyc < 200) begin
      case (mode)
        0:       out_ready_i = 1'b1;
        1:       out_ready_i = ($urandom_range(0, 3) != 0);
        default: begin
          if (k == 2 && stall < 3) begin
            out_ready_i = 1'b0;
            stall++;
          end else begin
            out_ready_i = 1'b1;
          end
        end
      endcase
      res_valid_i = 1'($urandom_range(0, 1));
      res_i       = LW'($urandom);
      start_i     = 1'($urandom_range(0, 1));
      @(negedge clock_i);
      exp_limb = exp_v[k*LW +: LW];
      check_eq($sformatf("%s.valid%0d", tag, k), out_valid_o, 1'b1);
      check_eq($sformatf("%s.data%0d", tag, k), out_data_o, exp_limb);
      check_eq($sformatf("%s.last%0d", tag, k), out_last_o, (k == S - 1));
      check_eq($sformatf("%s.done_early%0d", tag, k), done_o, 1'b0);
      if (out_ready_i) k++;
      tick();
      cyc++;
    end
    check_eq({tag, ".drain_count"}, k, S);
    if (mode == 0) check_eq({tag, ".back_to_back"}, cyc, S);
    start_i     = 1'b0;
    res_valid_i = 1'($urandom_range(0, 1));
    out_ready_i = 1'b0;
    @(negedge clock_i);
    check_eq({tag, ".done"}, done_o, 1'b1);
    check_eq({tag, ".busy_after"}, busy_o, 1'b0);
    check_eq({tag, ".valid_after"}, out_valid_o, 1'b0);
    tick();
    res_valid_i = 1'b0;
    @(negedge clock_i);
    check_eq({tag, ".done_one_cycle"}, done_o, 1'b0);
    tick();
  endtask

  task automatic run_reset_abort();
    $display("op reset_abort: two limbs then asynchronous reset");
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      res_valid_i = 1'b1;
      res_i       = LW'($urandom);
      tick();
    end
    res_valid_i = 1'b0;
    #2;
    check_eq("abort.busy_before", busy_o, 1'b1);
    reset_i = 1'b1;
    #1;
    check_eq("abort.busy", busy_o, 1'b0);
    check_eq("abort.valid", out_valid_o, 1'b0);
    check_eq("abort.done", done_o, 1'b0);
    @(negedge clock_i);
    #1;
    reset_i = 1'b0;
    tick();
  endtask

  function automatic logic [LW-1:0] rnd_limb();
    return LW'($urandom_range(0, (1 << LW) - 1));
  endfunction

  initial begin
    logic [S*LW-1:0] r;
    logic [S*LW-1:0] p;
    reset_i     = 1'b1;
    start_i     = 1'b0;
    res_valid_i = 1'b0;
    res_i       = '0;
    p_i         = '0;
    out_ready_i = 1'b0;
    #2;
    check_eq("rst.valid", out_valid_o, 1'b0);
    check_eq("rst.data", out_data_o, '0);
    check_eq("rst.last", out_last_o, 1'b0);
    check_eq("rst.busy", busy_o, 1'b0);
    check_eq("rst.done", done_o, 1'b0);
    repeat (2) @(posedge clock_i);
    #3;
    reset_i = 1'b0;
    tick();

    run_op("sub_basic", pack4(5, 0, 0, 1), pack4(3, 0, 0, 1), 0);
    run_op("res_lt_p", pack4(1, 0, 0, 1), pack4(3, 0, 0, 1), 0);
    run_op("res_eq_p", pack4(7, 2, 0, 1), pack4(7, 2, 0, 1), 0);
    run_op("ripple", pack4(0, 0, 0, 2), pack4(1, 0, 0, 1), 0);
    run_op("backpress", pack4(11, 22, 33, 44), pack4(1, 2, 3, 4), 2);
    run_reset_abort();
    run_op("after_rst", pack4(9, 8, 7, 6), pack4(10, 8, 7, 6), 0);
    run_op("max_limb", pack4(17'h1FFFF, 1, 2, 3), pack4(17'h1FFFF, 5, 5, 5), 1);

    for (int n = 0; n < 16; n++) begin
      r = pack4(rnd_limb(), rnd_limb(), rnd_limb(), rnd_limb());
      case ($urandom_range(0, 3))
        0:       p = r;
        1:       p = pack4(rnd_limb(), rnd_limb(), rnd_limb(), r[3*LW +: LW]);
        default: p = pack4(rnd_limb(), rnd_limb(), rnd_limb(), rnd_limb());
      endcase
      run_op($sformatf("rand%0d", n), r, p, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
